// File: rtl/usb_phy_pkg.sv
// rtl/usb_phy_pkg.sv - shared USB 3.0 PHY symbol constants and Gray-code helpers
//
// Purpose : 9-bit {K-flag, byte} symbol constants used by the receive path,
//           plus Gray/binary conversions for clock-crossing pointers.
//           The helpers work on PW_MAX bits. Callers zero-extend their
//           operand and truncate the result. Leading zeros do not change
//           a Gray/binary conversion, so this is exact for any width up
//           to PW_MAX.
// Ports   : none (package)
package usb_phy_pkg;

  localparam logic [8:0] K28_1   = 9'h13C;
  localparam logic [8:0] K28_5   = 9'h1BC;
  localparam logic [8:0] SKP_SYM = K28_1;

  localparam int PW_MAX = 16;

  function automatic logic [PW_MAX-1:0] bin2gray(input logic [PW_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [PW_MAX-1:0] gray2bin(input logic [PW_MAX-1:0] g);
    logic [PW_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PW_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/eb_ptr_sync.sv
// rtl/eb_ptr_sync.sv - two-flop synchroniser, parametrised width
//
// Purpose : Brings a Gray-coded pointer, or a 1-bit reset-release level,
//           into the clk domain through two flops.
//           The asynchronous clear lets a reset synchroniser assert
//           immediately. Release then happens two clk edges later.
// Ports   : clk   in  destination clock
//           rst_n in  asynchronous active-low clear
//           d     in  WIDTH  source-domain value
//           q     out WIDTH  value synchronised to clk
module eb_ptr_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_elastic_buf.sv
// rtl/usb_elastic_buf.sv - dual-clock elastic buffer with SKP drop/insert
//
// Purpose : Carries decoded symbols from the recovered clock (wclk) to the
//           local clock (rclk). It absorbs ppm drift as follows:
//           - A SKP arriving while the buffer runs high is dropped.
//           - A SKP at the head while the buffer runs low is replayed once.
// Ports   : wclk        in  write/recovered clock
//           rrst_n      in  async active-low reset, both domains
//           rclk        in  read/local clock
//           wdata       in  DSIZE   incoming symbol
//           wvalid      in  wdata valid this wclk
//           wfull       out buffer full (wclk domain)
//           wlevel      out ASIZE+1 occupancy seen from wclk
//           skp_removed out 1-cycle pulse: SKP dropped
//           overflow    out sticky: write lost because full
//           rready      in  consumer takes a symbol this rclk
//           rdata       out DSIZE   registered output symbol
//           rvalid      out rdata valid
//           rempty      out buffer empty (rclk domain)
//           rlevel      out ASIZE+1 occupancy seen from rclk
//           skp_added   out 1-cycle pulse: SKP duplicated
//           underflow   out sticky: rready while empty
module usb_elastic_buf #(
  parameter int               DSIZE   = 9,
  parameter int               ASIZE   = 4,
  parameter logic [DSIZE-1:0] SKP_SYM = DSIZE'(usb_phy_pkg::SKP_SYM),
  parameter int               HI_MARK = 12,
  parameter int               LO_MARK = 4
) (
  input  logic             wclk,
  input  logic             rrst_n,
  input  logic             rclk,
  input  logic [DSIZE-1:0] wdata,
  input  logic             wvalid,
  output logic             wfull,
  output logic [ASIZE:0]   wlevel,
  output logic             skp_removed,
  output logic             overflow,
  input  logic             rready,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic [ASIZE:0]   rlevel,
  output logic             skp_added,
  output logic             underflow
);
  import usb_phy_pkg::*;

  localparam int           PW     = ASIZE + 1;
  localparam int           DEPTH  = 1 << ASIZE;
  localparam logic [PW-1:0] HI_LVL = PW'(HI_MARK);
  localparam logic [PW-1:0] LO_LVL = PW'(LO_MARK);

  logic [DSIZE-1:0] mem [0:DEPTH-1];

  // Per-domain reset: asserts with rrst_n and releases on that domain's clock.
  logic w_rst_n, r_rst_n;

  eb_ptr_sync #(.WIDTH(1)) u_wrst_sync (
    .clk(wclk), .rst_n(rrst_n), .d(1'b1), .q(w_rst_n));
  eb_ptr_sync #(.WIDTH(1)) u_rrst_sync (
    .clk(rclk), .rst_n(rrst_n), .d(1'b1), .q(r_rst_n));

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wptr, wq2_rptr, wq2_rbin, wbin_next, wgray_next;
  logic          w_drop, w_inc, wfull_next;

  eb_ptr_sync #(.WIDTH(PW)) u_rptr_sync (
    .clk(wclk), .rst_n(w_rst_n), .d(rptr), .q(wq2_rptr));

  assign wq2_rbin   = PW'(gray2bin(PW_MAX'(wq2_rptr)));
  assign w_drop     = wvalid && (wdata == SKP_SYM) && (wlevel > HI_LVL);
  assign w_inc      = wvalid && !w_drop && !wfull;
  assign wbin_next  = wbin + PW'(w_inc);
  assign wgray_next = PW'(bin2gray(PW_MAX'(wbin_next)));
  // The write pointer is one full lap ahead of the read pointer.
  assign wfull_next = (wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      wfull       <= 1'b0;
      wlevel      <= '0;
      skp_removed <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      wfull       <= wfull_next;
      wlevel      <= wbin_next - wq2_rbin;
      skp_removed <= w_drop;
      if (wvalid && !w_drop && wfull) overflow <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (w_inc) mem[wbin[ASIZE-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0]    rbin, rptr, rq2_wptr, rq2_wbin, rbin_next, rgray_next;
  logic [DSIZE-1:0] head;
  logic             r_avail, r_ins, r_adv, rempty_next, ins_flag;

  eb_ptr_sync #(.WIDTH(PW)) u_wptr_sync (
    .clk(rclk), .rst_n(r_rst_n), .d(wptr), .q(rq2_wptr));

  assign rq2_wbin = PW'(gray2bin(PW_MAX'(rq2_wptr)));
  assign head     = mem[rbin[ASIZE-1:0]];
  assign r_avail  = rready && !rempty;
  // Replay a head SKP without advancing. ins_flag prevents a replay from
  // triggering a second replay back to back.
  assign r_ins    = r_avail && (head == SKP_SYM) && (rlevel < LO_LVL) && !ins_flag;
  assign r_adv    = r_avail && !r_ins;
  assign rbin_next   = rbin + PW'(r_adv);
  assign rgray_next  = PW'(bin2gray(PW_MAX'(rbin_next)));
  assign rempty_next = (rgray_next == rq2_wptr);

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin      <= '0;
      rptr      <= '0;
      rempty    <= 1'b1;
      rlevel    <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      skp_added <= 1'b0;
      ins_flag  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr      <= rgray_next;
      rempty    <= rempty_next;
      rlevel    <= rq2_wbin - rbin_next;
      rvalid    <= r_avail;
      skp_added <= r_ins;
      if (r_avail) rdata <= head;
      if (r_ins) ins_flag <= 1'b1;
      else if (r_adv) ins_flag <= 1'b0;
      if (rready && rempty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_elastic_buf.sv
// tb/tb_usb_elastic_buf.sv - scoreboard bench for usb_elastic_buf
`timescale 1ns/1fs
module tb_usb_elastic_buf;

  localparam logic [8:0] SKP  = 9'h13C;
  localparam int         NSYM = 20000;

  logic       wclk = 1'b0, rclk = 1'b0, rrst_n;
  logic [8:0] wdata, rdata;
  logic       wvalid, rready;
  logic       wfull, rvalid, rempty, skp_removed, skp_added, overflow, underflow;
  logic [4:0] wlevel, rlevel;

  int n_tests = 0, n_fail = 0;
  int n_removed = 0, n_added = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_val;
  bit   skip_skp = 1'b0;
  bit   wr_done  = 1'b0;
  bit   found;
  int   base;

  // 250.000 MHz recovered clock, 250.075 MHz local clock (+300 ppm)
  always #2.0    wclk = ~wclk;
  always #1.9994 rclk = ~rclk;

  usb_elastic_buf dut (
    .wclk(wclk), .rrst_n(rrst_n), .rclk(rclk),
    .wdata(wdata), .wvalid(wvalid), .wfull(wfull), .wlevel(wlevel),
    .skp_removed(skp_removed), .overflow(overflow),
    .rready(rready), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .rlevel(rlevel), .skp_added(skp_added), .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every valid symbol is compared with the scoreboard head.
  always @(negedge rclk) begin
    if (rvalid) begin
      if (skip_skp && rdata == SKP) begin
        // SKP count is elastic during the drift run
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got 0x%0h expected nothing", rdata);
      end else begin
        exp_val = exp_q.pop_front();
        check("rdata", 32'(rdata), 32'(exp_val));
      end
    end
  end

  always @(negedge wclk) if (skp_removed) n_removed++;
  always @(negedge rclk) if (skp_added)   n_added++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [8:0] d);
    @(negedge wclk);
    wdata  = d;
    wvalid = 1'b1;
  endtask

  task automatic wr_idle();
    @(negedge wclk);
    wvalid = 1'b0;
  endtask

  task automatic rd(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      @(negedge rclk);
      if (chk && i > 0) check("rd_latency", 32'(rvalid), 32'd1);
      rready = 1'b1;
    end
    @(negedge rclk);
    if (chk) check("rd_latency", 32'(rvalid), 32'd1);
    rready = 1'b0;
  endtask

  task automatic release_reset();
    rrst_n = 1'b1;
    repeat (4) @(negedge wclk);
    repeat (4) @(negedge rclk);
  endtask

  initial begin
    rrst_n = 1'b0;
    wvalid = 1'b0;
    wdata  = '0;
    rready = 1'b0;
    repeat (3) @(negedge wclk);
    check("rst_rdata",       32'(rdata),       32'd0);
    check("rst_rvalid",      32'(rvalid),      32'd0);
    check("rst_rempty",      32'(rempty),      32'd1);
    check("rst_wfull",       32'(wfull),       32'd0);
    check("rst_wlevel",      32'(wlevel),      32'd0);
    check("rst_rlevel",      32'(rlevel),      32'd0);
    check("rst_skp_removed", 32'(skp_removed), 32'd0);
    check("rst_skp_added",   32'(skp_added),   32'd0);
    check("rst_overflow",    32'(overflow),    32'd0);
    check("rst_underflow",   32'(underflow),   32'd0);
    release_reset();

    // 8 symbols in, 8 out in order
    for (int i = 1; i <= 8; i++) begin
      wr(9'(i));
      exp_q.push_back(9'(i));
    end
    wr_idle();
    repeat (6) @(negedge rclk);
    check("t1_rlevel", 32'(rlevel), 32'd8);
    check("t1_rempty", 32'(rempty), 32'd0);
    rd(8, 1'b1);
    repeat (6) @(negedge rclk);
    check("t1_rempty_after", 32'(rempty), 32'd1);
    check("t1_rlevel_after", 32'(rlevel), 32'd0);
    check("t1_scoreboard",   32'(exp_q.size()), 32'd0);

    // fill to full, then one lost write
    for (int i = 0; i < 16; i++) begin
      wr(9'h010 + 9'(i));
      exp_q.push_back(9'h010 + 9'(i));
    end
    wr_idle();
    repeat (2) @(negedge wclk);
    check("t2_wfull",    32'(wfull),    32'd1);
    check("t2_wlevel",   32'(wlevel),   32'd16);
    check("t2_no_ovf",   32'(overflow), 32'd0);
    wr(9'h0FF);
    wr_idle();
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_wlevel17", 32'(wlevel),   32'd16);
    rd(16, 1'b0);
    repeat (6) @(negedge rclk);
    check("t2_scoreboard", 32'(exp_q.size()), 32'd0);
    check("t2_rempty",     32'(rempty),       32'd1);

    // SKP dropped above the high mark
    for (int i = 0; i < 13; i++) begin
      wr(9'h020 + 9'(i));
      exp_q.push_back(9'h020 + 9'(i));
    end
    wr_idle();
    repeat (2) @(negedge wclk);
    check("t3_wlevel13", 32'(wlevel), 32'd13);
    base = n_removed;
    wr(SKP);
    wr_idle();
    repeat (3) @(negedge wclk);
    check("t3_skp_removed", 32'(n_removed - base), 32'd1);
    check("t3_wlevel_kept", 32'(wlevel), 32'd13);
    rd(13, 1'b0);
    repeat (6) @(negedge rclk);
    check("t3_scoreboard", 32'(exp_q.size()), 32'd0);

    // SKP duplicated below the low mark
    wr(SKP);
    wr(9'h0BC);
    wr_idle();
    exp_q.push_back(SKP);
    exp_q.push_back(SKP);
    exp_q.push_back(9'h0BC);
    repeat (6) @(negedge rclk);
    check("t4_rlevel", 32'(rlevel), 32'd2);
    base = n_added;
    rd(3, 1'b1);
    repeat (3) @(negedge rclk);
    check("t4_skp_added",  32'(n_added - base), 32'd1);
    check("t4_rempty",     32'(rempty),         32'd1);
    check("t4_scoreboard", 32'(exp_q.size()),   32'd0);

    // underflow, then a late symbol with rready held
    @(negedge rclk);
    rready = 1'b1;
    repeat (3) @(negedge rclk);
    check("t5_rvalid",    32'(rvalid),    32'd0);
    check("t5_underflow", 32'(underflow), 32'd1);
    wr(9'h055);
    exp_q.push_back(9'h055);
    wr_idle();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge rclk);
      if (!rempty) found = 1'b1;
    end
    check("t5_rempty_drop", 32'(found), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge rclk);
      if (rvalid) found = 1'b1;
    end
    check("t5_latency", 32'(found), 32'd1);
    rready = 1'b0;
    repeat (2) @(negedge rclk);
    check("t5_scoreboard", 32'(exp_q.size()), 32'd0);

    // reset mid-operation discards contents
    wr(9'h0AA);
    wr(9'h0AB);
    wr_idle();
    repeat (6) @(negedge rclk);
    rrst_n = 1'b0;
    repeat (3) @(negedge wclk);
    check("mr_overflow",  32'(overflow),  32'd0);
    check("mr_underflow", 32'(underflow), 32'd0);
    check("mr_wlevel",    32'(wlevel),    32'd0);
    check("mr_rlevel",    32'(rlevel),    32'd0);
    check("mr_rempty",    32'(rempty),    32'd1);
    release_reset();

    // +300 ppm drift with an SKP every 20 symbols
    skip_skp = 1'b1;
    fork
      begin
        for (int i = 0; i < NSYM; i++) begin
          @(negedge wclk);
          wvalid = 1'b1;
          if (i % 20 == 19) begin
            wdata = SKP;
          end else begin
            wdata = {1'b0, 8'(i)};
            exp_q.push_back(wdata);
          end
        end
        @(negedge wclk);
        wvalid  = 1'b0;
        wr_done = 1'b1;
      end
      begin
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
          @(negedge rclk);
          if (rlevel >= 5'd6) found = 1'b1;
        end
        check("t6_prefill", 32'(found), 32'd1);
        rready = 1'b1;
        while (!wr_done) @(negedge rclk);
        for (int k = 0; k < 100; k++) begin
          @(negedge rclk);
          rready = !rempty;
        end
        rready = 1'b0;
      end
    join
    repeat (4) @(negedge rclk);
    check("t6_overflow",   32'(overflow),       32'd0);
    check("t6_underflow",  32'(underflow),      32'd0);
    check("t6_scoreboard", 32'(exp_q.size()),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
